ps2_command_decoder: RTL and testbench



---
 rtl/ps2_command_decoder.sv | 157 +++++++++++++++
 tb/tb_ps2_command_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_decoder.sv
// rtl/ps2_command_decoder.sv - PS/2 set-2 scan byte decoder to held-level and toggle controls
//
// Purpose: parses make/break (F0) and extended (E0) prefixes from a stream of
// PS/2 set-2 scan bytes. It drives one held-level output per configured hold
// code and one press-toggled output per configured toggle code. Typematic
// repeats of a key that is already down are ignored.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   key_code   scan byte, qualified by key_valid
//   key_valid  one-cycle strobe per received byte
//   hold_out   bit i high while key HOLD_CODES[i] is down
//   toggle_out bit j inverts on each fresh press of TOGGLE_CODES[j]
//   cmd_pulse  one-cycle pulse on a fresh make that changed any output
//   prefix_err one-cycle pulse when a prefix state times out

module ps2_command_decoder #(
  parameter int                     N_HOLD       = 5,
  parameter int                     N_TOGGLE     = 2,
  parameter logic [9*N_HOLD-1:0]    HOLD_CODES   = {9'h05A, 9'h06B, 9'h074, 9'h072, 9'h075},
  parameter logic [9*N_TOGGLE-1:0]  TOGGLE_CODES = {9'h076, 9'h029},
  parameter int                     TIMEOUT_CYC  = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          key_code,
  input  logic                key_valid,
  output logic [N_HOLD-1:0]   hold_out,
  output logic [N_TOGGLE-1:0] toggle_out,
  output logic                cmd_pulse,
  output logic                prefix_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [N_TOGGLE-1:0] down;

  logic                is_e0;
  logic                is_f0;
  logic                key_ev;
  logic                key_brk;
  logic [8:0]          key_id;
  logic [N_HOLD-1:0]   hold_hit;
  logic [N_TOGGLE-1:0] tog_hit;
  logic [N_HOLD-1:0]   hold_next;
  logic [N_TOGGLE-1:0] toggle_next;
  logic [N_TOGGLE-1:0] down_next;
  logic                fresh;

  // Decode the byte on the wire against the current prefix context. Only a
  // non-prefix byte completes a key event; the prefix state tells make/break
  // and plain/extended apart.
  always_comb begin
    is_e0   = (key_code == 8'hE0);
    is_f0   = (key_code == 8'hF0);
    key_ev  = key_valid && !is_e0 && !is_f0;
    key_brk = (state == S_BRK) || (state == S_EXT_BRK);
    key_id  = {(state == S_EXT) || (state == S_EXT_BRK), key_code};

    for (int i = 0; i < N_HOLD; i++) begin
      hold_hit[i] = key_ev && (key_id == HOLD_CODES[9*i +: 9]);
    end
    for (int j = 0; j < N_TOGGLE; j++) begin
      tog_hit[j] = key_ev && (key_id == TOGGLE_CODES[9*j +: 9]);
    end
  end

  // Next output values. A channel only reports a fresh command when its state
  // actually moves, so a repeat of a key already down leaves fresh low.
  always_comb begin
    hold_next   = hold_out;
    toggle_next = toggle_out;
    down_next   = down;
    fresh       = 1'b0;

    for (int i = 0; i < N_HOLD; i++) begin
      if (hold_hit[i]) begin
        if (key_brk) begin
          hold_next[i] = 1'b0;
        end else begin
          hold_next[i] = 1'b1;
          if (!hold_out[i]) fresh = 1'b1;
        end
      end
    end

    for (int j = 0; j < N_TOGGLE; j++) begin
      if (tog_hit[j]) begin
        if (key_brk) begin
          down_next[j] = 1'b0;
        end else if (!down[j]) begin
          down_next[j]   = 1'b1;
          toggle_next[j] = ~toggle_out[j];
          fresh          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      down       <= '0;
      hold_out   <= '0;
      toggle_out <= '0;
      cmd_pulse  <= 1'b0;
      prefix_err <= 1'b0;
    end else begin
      hold_out   <= hold_next;
      toggle_out <= toggle_next;
      down       <= down_next;
      cmd_pulse  <= fresh;
      prefix_err <= 1'b0;

      if (key_valid) begin
        // Any byte restarts the wait; a byte on the final count cycle is
        // decoded normally rather than losing to the timeout.
        cnt <= '0;
        case (state)
          S_IDLE: begin
            if (is_e0)      state <= S_EXT;
            else if (is_f0) state <= S_BRK;
          end
          S_EXT: begin
            if (is_f0)       state <= S_EXT_BRK;
            else if (!is_e0) state <= S_IDLE;
          end
          S_BRK, S_EXT_BRK: begin
            if (!is_e0 && !is_f0) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (cnt >= CNT_LAST) begin
          state      <= S_IDLE;
          cnt        <= '0;
          prefix_err <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_decoder.sv
// tb/tb_ps2_command_decoder.sv - self-checking bench for ps2_command_decoder
module tb_ps2_command_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0;

  logic [4:0] hold_a, hold_b;
  logic [1:0] tog_a, tog_b;
  logic       pulse_a, pulse_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance A: default code lists. Instance B: extended 75 on channel 0,
  // duplicated on channel 3, and 29 shared with the toggle list.
  ps2_command_decoder #(
    .N_HOLD(5), .N_TOGGLE(2),
    .HOLD_CODES({9'h05A, 9'h06B, 9'h074, 9'h072, 9'h075}),
    .TOGGLE_CODES({9'h076, 9'h029}),
    .TIMEOUT_CYC(TO)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .hold_out(hold_a), .toggle_out(tog_a), .cmd_pulse(pulse_a), .prefix_err(err_a)
  );

  ps2_command_decoder #(
    .N_HOLD(5), .N_TOGGLE(2),
    .HOLD_CODES({9'h029, 9'h175, 9'h074, 9'h072, 9'h175}),
    .TOGGLE_CODES({9'h076, 9'h029}),
    .TIMEOUT_CYC(TO)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .hold_out(hold_b), .toggle_out(tog_b), .cmd_pulse(pulse_b), .prefix_err(err_b)
  );

  // Reference model: prefix flags plus an idle-cycle count, and per-instance
  // key tables.
  logic [8:0] hc [2][5];
  logic [8:0] tc [2];
  logic [4:0] m_hold [2];
  logic [1:0] m_tog  [2];
  logic [1:0] m_down [2];
  logic       m_pulse [2];
  logic       m_err;
  bit         m_pre, m_ext, m_brk;
  int         m_idle;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_hold[d] = '0; m_tog[d] = '0; m_down[d] = '0; m_pulse[d] = 1'b0;
    end
    m_err = 1'b0; m_pre = 0; m_ext = 0; m_brk = 0; m_idle = 0;
  endfunction

  function automatic void apply_key(input logic [8:0] id, input bit brk);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) begin
        if (id == hc[d][i]) begin
          if (brk) m_hold[d][i] = 1'b0;
          else if (!m_hold[d][i]) begin m_hold[d][i] = 1'b1; m_pulse[d] = 1'b1; end
        end
      end
      for (int j = 0; j < 2; j++) begin
        if (id == tc[j]) begin
          if (brk) m_down[d][j] = 1'b0;
          else if (!m_down[d][j]) begin
            m_down[d][j] = 1'b1; m_tog[d][j] = ~m_tog[d][j]; m_pulse[d] = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic void model_edge(input bit kv, input logic [7:0] code);
    m_err = 1'b0; m_pulse[0] = 1'b0; m_pulse[1] = 1'b0;
    if (kv) begin
      if (code == 8'hE0) begin
        if (!m_pre) m_ext = 1;
        m_pre = 1; m_idle = 0;
      end else if (code == 8'hF0) begin
        m_brk = 1; m_pre = 1; m_idle = 0;
      end else begin
        apply_key({m_ext, code}, m_brk);
        m_pre = 0; m_ext = 0; m_brk = 0; m_idle = 0;
      end
    end else if (m_pre) begin
      m_idle++;
      if (m_idle == TO) begin
        m_pre = 0; m_ext = 0; m_brk = 0; m_idle = 0; m_err = 1'b1;
      end
    end
  endfunction

  // Drive one cycle of input; returns 1 ns after the active edge.
  task automatic step(input bit kv, input logic [7:0] code);
    key_valid = kv;
    key_code  = code;
    @(posedge clk);
    model_edge(kv, code);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({hold_a, tog_a, pulse_a, err_a, hold_b, tog_b, pulse_b, err_b} !== 18'h0) begin
      errors++;
      $display("FAIL reset got a=%h/%h/%b/%b b=%h/%h/%b/%b expected all 0",
               hold_a, tog_a, pulse_a, err_a, hold_b, tog_b, pulse_b, err_b);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_hold();
    reset_dut();
    step(1, 8'h75);
    checks++;
    if (hold_a !== 5'h01 || pulse_a !== 1'b1) begin
      errors++; $display("FAIL hold_make got hold=%h pulse=%b expected 01/1", hold_a, pulse_a);
    end
    step(0, 8'h00);
    checks++;
    if (hold_a !== 5'h01 || pulse_a !== 1'b0) begin
      errors++; $display("FAIL hold_pulse_width got hold=%h pulse=%b expected 01/0", hold_a, pulse_a);
    end
    step(1, 8'hF0);
    step(1, 8'h75);
    checks++;
    if (hold_a !== 5'h00 || pulse_a !== 1'b0) begin
      errors++; $display("FAIL hold_break got hold=%h pulse=%b expected 00/0", hold_a, pulse_a);
    end
  endtask

  task automatic test_toggle();
    int pulses;
    reset_dut();
    pulses = 0;
    step(1, 8'h29); pulses += pulse_a;
    checks++;
    if (tog_a !== 2'b01) begin
      errors++; $display("FAIL toggle_first got %b expected 01", tog_a);
    end
    step(1, 8'h29); pulses += pulse_a;
    step(1, 8'h29); pulses += pulse_a;
    step(1, 8'hF0); pulses += pulse_a;
    step(1, 8'h29); pulses += pulse_a;
    step(0, 8'h00); pulses += pulse_a;
    checks++;
    if (tog_a !== 2'b01 || pulses != 1) begin
      errors++; $display("FAIL toggle_typematic got tog=%b pulses=%0d expected 01/1", tog_a, pulses);
    end
    step(1, 8'h29);
    checks++;
    if (tog_a !== 2'b00 || pulse_a !== 1'b1) begin
      errors++; $display("FAIL toggle_second got tog=%b pulse=%b expected 00/1", tog_a, pulse_a);
    end
    step(1, 8'hF0);
    step(1, 8'h29);
  endtask

  task automatic test_ext();
    reset_dut();
    step(1, 8'h75);
    checks++;
    if (hold_b !== 5'h00 || hold_a !== 5'h01) begin
      errors++; $display("FAIL ext_plain got b=%h a=%h expected 00/01", hold_b, hold_a);
    end
    step(1, 8'hE0);
    step(1, 8'h75);
    checks++;
    if (hold_b !== 5'h09 || pulse_b !== 1'b1) begin
      errors++; $display("FAIL ext_make_dup got b=%h pulse=%b expected 09/1", hold_b, pulse_b);
    end
    step(1, 8'hE0);
    step(1, 8'hF0);
    step(1, 8'h75);
    checks++;
    if (hold_b !== 5'h00 || hold_a !== 5'h01) begin
      errors++; $display("FAIL ext_break got b=%h a=%h expected 00/01", hold_b, hold_a);
    end
    step(1, 8'h29);
    checks++;
    if (hold_b !== 5'h10 || tog_b !== 2'b01) begin
      errors++; $display("FAIL both_lists got hold=%h tog=%b expected 10/01", hold_b, tog_b);
    end
  endtask

  task automatic test_timeout();
    int early;
    reset_dut();
    step(1, 8'hF0);
    early = 0;
    for (int c = 0; c < TO - 1; c++) begin
      step(0, 8'h00);
      early += err_a;
    end
    step(0, 8'h00);
    checks++;
    if (err_a !== 1'b1 || early != 0) begin
      errors++; $display("FAIL timeout_fire got err=%b early=%0d expected 1/0", err_a, early);
    end
    step(0, 8'h00);
    checks++;
    if (err_a !== 1'b0) begin
      errors++; $display("FAIL timeout_width got err=%b expected 0", err_a);
    end
    step(1, 8'h75);
    checks++;
    if (hold_a !== 5'h01 || pulse_a !== 1'b1) begin
      errors++; $display("FAIL timeout_idle got hold=%h pulse=%b expected 01/1", hold_a, pulse_a);
    end
  endtask

  task automatic test_boundary();
    reset_dut();
    step(1, 8'h75);
    step(1, 8'hF0);
    for (int c = 0; c < TO - 1; c++) step(0, 8'h00);
    step(1, 8'h75);
    checks++;
    if (hold_a !== 5'h00 || err_a !== 1'b0) begin
      errors++; $display("FAIL boundary got hold=%h err=%b expected 00/0", hold_a, err_a);
    end
    step(0, 8'h00);
    checks++;
    if (err_a !== 1'b0) begin
      errors++; $display("FAIL boundary_after got err=%b expected 0", err_a);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] keys [7];
    keys = '{8'h75, 8'h72, 8'h74, 8'h6B, 8'h5A, 8'h29, 8'h76};
    reset_dut();
    foreach (keys[k]) step(1, keys[k]);
    checks++;
    if (hold_a !== 5'h1F || tog_a !== 2'b11) begin
      errors++; $display("FAIL preload got hold=%h tog=%b expected 1F/11", hold_a, tog_a);
    end
    step(1, 8'hE0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hold_a, tog_a, pulse_a, err_a} !== 9'h0) begin
      errors++; $display("FAIL async_reset got hold=%h tog=%b expected 00/00", hold_a, tog_a);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step(1, 8'h76);
    checks++;
    if (tog_a !== 2'b10 || hold_a !== 5'h00 || pulse_a !== 1'b1) begin
      errors++; $display("FAIL post_reset got tog=%b hold=%h pulse=%b expected 10/00/1",
                         tog_a, hold_a, pulse_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    logic [7:0] b;
    int bad;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h5A, 8'h29, 8'h76, 8'hAA, 8'hFA, 8'hE1};
    reset_dut();
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 40) == 0) begin
        int gap;
        gap = $urandom_range(TO - 2, TO + 2);
        for (int g = 0; g < gap; g++) step(0, 8'h00);
      end
      if ($urandom_range(0, 2) != 0) begin
        b = ($urandom_range(0, 12) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
        step(1, b);
      end else begin
        step(0, 8'h00);
      end
      checks++;
      if ({hold_a, tog_a, pulse_a, err_a} !== {m_hold[0], m_tog[0], m_pulse[0], m_err} ||
          {hold_b, tog_b, pulse_b, err_b} !== {m_hold[1], m_tog[1], m_pulse[1], m_err}) begin
        errors++;
        if (bad < 10)
          $display("FAIL random n=%0d got a=%h/%b/%b/%b b=%h/%b/%b/%b expected a=%h/%b/%b/%b b=%h/%b/%b/%b",
                   n, hold_a, tog_a, pulse_a, err_a, hold_b, tog_b, pulse_b, err_b,
                   m_hold[0], m_tog[0], m_pulse[0], m_err, m_hold[1], m_tog[1], m_pulse[1], m_err);
        bad++;
      end
    end
  endtask

  initial begin
    hc[0] = '{9'h075, 9'h072, 9'h074, 9'h06B, 9'h05A};
    hc[1] = '{9'h175, 9'h072, 9'h074, 9'h175, 9'h029};
    tc    = '{9'h029, 9'h076};
    model_reset();

    test_reset();
    test_hold();
    test_toggle();
    test_ext();
    test_timeout();
    test_boundary();
    test_async_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
